// File: rtl/sw_debounce4_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
//   Shared constants for the four-switch debounce stage: channel bit positions,
//   the board-clock default for the stability window, a short window for
//   simulation, and a range check for the window/counter-width pairing.
// -----------------------------------------------------------------------------
package sw_pkg;

  // Bit position of each switch inside the N_CH-wide vectors.
  localparam int CH_A = 3;
  localparam int CH_B = 2;
  localparam int CH_C = 1;
  localparam int CH_D = 0;

  localparam int N_CH_DEFAULT          = 4;
  localparam int CNT_W_DEFAULT         = 16;
  // About 1 ms of required stability on the 50 MHz board clock.
  localparam int STABLE_CYCLES_DEFAULT = 50000;
  // Short window so a bench can watch whole debounce cycles quickly.
  localparam int SIM_STABLE_CYCLES     = 4;

  // The terminal count STABLE_CYCLES-1 must be representable in CNT_W bits,
  // and a window of zero cycles is meaningless.
  function automatic bit stable_cycles_ok(input int stable_cycles, input int cnt_w);
    return (stable_cycles > 0) &&
           (longint'(stable_cycles) < (longint'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/sw_debounce4_if.sv
// -----------------------------------------------------------------------------
// sw_debounce4_if
//   Signal bundle between the switch pins and the debounce stage, and between
//   the debounce stage and the downstream LED logic.
//     sw_raw  : raw, asynchronous, bouncy switch levels (into the debouncer)
//     sw_out  : debounced levels
//     sw_rise : one-cycle pulse per channel on a debounced 0->1
//     sw_fall : one-cycle pulse per channel on a debounced 1->0
//     changed : one-cycle pulse whenever any channel changes
//   master = side that drives sw_raw and consumes the results.
//   slave  = the debounce stage itself.
// -----------------------------------------------------------------------------
interface sw_debounce4_if
  import sw_pkg::*;
#(
  parameter int N_CH = N_CH_DEFAULT
);
  logic [N_CH-1:0] sw_raw;
  logic [N_CH-1:0] sw_out;
  logic [N_CH-1:0] sw_rise;
  logic [N_CH-1:0] sw_fall;
  logic            changed;

  modport master (
    output sw_raw,
    input  sw_out, sw_rise, sw_fall, changed
  );

  modport slave (
    input  sw_raw,
    output sw_out, sw_rise, sw_fall, changed
  );
endinterface

// File: rtl/sw_debounce4_debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
//   One switch channel: two-flop synchroniser, stability counter, debounced
//   output flop and registered rise/fall pulses.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     raw        : raw switch level, asynchronous to clk
//     out        : debounced level
//     rise, fall : one-cycle pulses in the cycle 'out' changes
//   The output follows the synchronised input only after it has differed from
//   'out' for STABLE_CYCLES consecutive edges; any return to the current level
//   restarts the count from zero.
// -----------------------------------------------------------------------------
module debounce_ch #(
  parameter int   CNT_W         = 16,
  parameter int   STABLE_CYCLES = 50000,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: every flop, the counter included, is in the async reset branch so
  // no state can come up X and a reset mid-count discards the partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RESET_BIT;
      sync2 <= RESET_BIT;
      out   <= RESET_BIT;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving
      // two real flop stages; blocking here would collapse them into one.
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;

      if (sync2 == out) begin
        cnt <= '0;
      end else if (cnt == CNT_TERM) begin
        // Deviation has now lasted STABLE_CYCLES edges: accept it.
        out  <= sync2;
        cnt  <= '0;
        rise <= sync2;
        fall <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_debounce4.sv
// -----------------------------------------------------------------------------
// sw_debounce4
//   Input conditioning for the four lab switches (A=bit3 .. D=bit0). Each raw
//   switch is synchronised and debounced independently; the clean levels feed
//   the downstream sum-of-products LED stage.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : sw_debounce4_if.slave (sw_raw in; sw_out, sw_rise, sw_fall,
//             changed out)
//   'changed' is the OR of registered pulses, so it is glitch-free and lines
//   up with the cycle in which sw_out changes.
// -----------------------------------------------------------------------------
module sw_debounce4
  import sw_pkg::*;
#(
  parameter int              N_CH          = N_CH_DEFAULT,
  parameter int              CNT_W         = CNT_W_DEFAULT,
  parameter int              STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter logic [N_CH-1:0] RESET_VAL     = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  sw_debounce4_if.slave bus
);

  if (!stable_cycles_ok(STABLE_CYCLES, CNT_W)) begin : g_bad_cfg
    $fatal(1, "sw_debounce4: STABLE_CYCLES=%0d out of range for CNT_W=%0d",
           STABLE_CYCLES, CNT_W);
  end

  logic [N_CH-1:0] out_v;
  logic [N_CH-1:0] rise_v;
  logic [N_CH-1:0] fall_v;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_W         (CNT_W),
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_BIT     (RESET_VAL[i])
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.sw_raw[i]),
      .out   (out_v[i]),
      .rise  (rise_v[i]),
      .fall  (fall_v[i])
    );
  end

  assign bus.sw_out  = out_v;
  assign bus.sw_rise = rise_v;
  assign bus.sw_fall = fall_v;
  assign bus.changed = |(rise_v | fall_v);

endmodule

// File: tb/tb_sw_debounce4.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce4
//   Directed stimulus with a scoreboard. Each stimulus step that should cause a
//   debounced change pushes the expected {edge, sw_out, sw_rise, sw_fall} into
//   a queue; a monitor on the falling edge pops one entry whenever the DUT
//   shows any pulse and compares it, so an early, late, missing or spurious
//   pulse is reported. With STABLE_CYCLES=4 a raw change driven just before
//   edge k shows up after edge k+5, i.e. 6 edges after the drive point.
// -----------------------------------------------------------------------------
module tb_sw_debounce4;
  import sw_pkg::*;

  localparam int SC  = SIM_STABLE_CYCLES;
  localparam int LAT = SC + 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sw_debounce4_if #(.N_CH(4)) bus ();

  sw_debounce4 #(
    .N_CH          (4),
    .CNT_W         (16),
    .STABLE_CYCLES (SC),
    .RESET_VAL     (4'b0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         at;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_vec    = 0;
  int   n_bad    = 0;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Stand-in for the downstream sum-of-products LED stage.
  function automatic logic led_ref(input logic [3:0] s);
    return ~s[CH_A] | ~s[CH_B] | ~s[CH_C] | ~s[CH_D];
  endfunction

  // Monitor: every pulse cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.changed || (|bus.sw_rise) || (|bus.sw_fall)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_pulse: out=%b rise=%b fall=%b changed=%b, want no pulse (edge %0d)",
                 bus.sw_out, bus.sw_rise, bus.sw_fall, bus.changed, edge_cnt);
      end else begin
        automatic exp_t e;
        e = sb.pop_front();
        check("pulse_edge",    edge_cnt,                    e.at);
        check("pulse_out",     bus.sw_out,                  e.out);
        check("pulse_rise",    bus.sw_rise,                 e.rise);
        check("pulse_fall",    bus.sw_fall,                 e.fall);
        check("pulse_changed", bus.changed,                 1);
        check("rise_fall_excl", |(bus.sw_rise & bus.sw_fall), 0);
      end
    end
  end

  // Drive a raw vector on a falling edge and record the change it must cause.
  task automatic expect_change(input logic [3:0] raw, input logic [3:0] out,
                               input logic [3:0] rise, input logic [3:0] fall);
    @(negedge clk);
    bus.sw_raw = raw;
    sb.push_back('{edge_cnt + LAT, out, rise, fall});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d expected pulses pending, want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_state(input string name);
    check(name,             bus.sw_out, 4'b0000);
    check({name, "_pulse"}, {bus.sw_rise, bus.sw_fall, bus.changed}, 0);
  endtask

  typedef struct {
    logic [3:0] v;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       led;
  } ds_t;

  ds_t ds_tab[4] = '{
    '{4'b0100, 4'b0100, 4'b1000, 1'b1},
    '{4'b1000, 4'b1000, 4'b0100, 1'b1},
    '{4'b0000, 4'b0000, 4'b1000, 1'b1},
    '{4'b1111, 4'b1111, 4'b0000, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    bus.sw_raw = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_out", bus.sw_out, 4'b0000);

    // Async reset mid-cycle with all switches high; hold it.
    bus.sw_raw = 4'b1111;
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_async");
    repeat (8) @(negedge clk);
    check_reset_state("rst_hold");
    bus.sw_raw = 4'b0000;
    rst_n      = 1'b1;
    repeat (3) @(negedge clk);

    // Clean rise on A.
    expect_change(4'b1000, 4'b1000, 4'b1000, 4'b0000);
    drain(20);

    // Bounce on C: 3-cycle holds never reach the 4-edge window.
    for (int i = 0; i < 10; i++) begin
      bus.sw_raw[CH_C] = ~bus.sw_raw[CH_C];
      repeat (3) @(negedge clk);
    end
    check("bounce_out", bus.sw_out, 4'b1000);
    expect_change(4'b1010, 4'b1010, 4'b0010, 4'b0000);
    drain(20);

    // Simultaneous fall on C and rise on D.
    expect_change(4'b1001, 4'b1001, 4'b0001, 4'b0010);
    drain(20);

    // Clear everything, then reset with A's count at 2.
    expect_change(4'b0000, 4'b0000, 4'b0000, 4'b1001);
    drain(20);
    @(negedge clk);
    bus.sw_raw = 4'b1000;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_state("midcount_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{edge_cnt + LAT, 4'b1000, 4'b1000, 4'b0000});
    repeat (LAT - 1) @(negedge clk);
    check("midcount_hold", bus.sw_out, 4'b0000);
    drain(20);

    // Settled states through the downstream LED logic.
    for (int i = 0; i < 4; i++) begin
      expect_change(ds_tab[i].v, ds_tab[i].v, ds_tab[i].rise, ds_tab[i].fall);
      drain(20);
      check("settle_out", bus.sw_out,          ds_tab[i].v);
      check("led",        led_ref(bus.sw_out), ds_tab[i].led);
    end

    // Async reset with every output high clears them before any clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_from_1111");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
